// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory request controller.
package mem_req_ctrl_pkg;

  // Memory operation carried in the EX/MEM register.
  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_t;

  // Request FSM: idle / request outstanding / done but pipeline still held.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_ctrl_state_t;

  // Byte-enable patterns before lane shifting.
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Word-aligned form of a byte address.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_req_ctrl_align.sv
// Combinational alignment unit: converts op/address/store data into byte
// enables, lane-shifted store data and a misalignment flag.
module mem_req_ctrl_align
  import mem_req_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic        misaligned,
  output logic        op_valid
);

  mem_op_t op_s;
  logic [1:0] lane_s;

  assign op_s   = mem_op_t'(op);
  assign lane_s = addr[1:0];

  // Decode op into masks/shift; unknown encodings behave like MOP_NONE.
  always_comb begin
    rmask      = 4'b0000;
    wmask      = 4'b0000;
    wdata_sh   = 32'h0000_0000;
    misaligned = 1'b0;
    op_valid   = 1'b1;
    case (op_s)
      MOP_LB, MOP_LBU: begin
        rmask = MASK_B << lane_s;
      end
      MOP_LH, MOP_LHU: begin
        if (lane_s[0]) begin
          misaligned = 1'b1;
        end else begin
          rmask = MASK_H << {lane_s[1], 1'b0};
        end
      end
      MOP_LW: begin
        if (lane_s != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          rmask = MASK_W;
        end
      end
      MOP_SB: begin
        wmask    = MASK_B << lane_s;
        wdata_sh = wdata << {lane_s, 3'b000};
      end
      MOP_SH: begin
        if (lane_s[0]) begin
          misaligned = 1'b1;
        end else begin
          wmask    = MASK_H << {lane_s[1], 1'b0};
          wdata_sh = wdata << {lane_s[1], 4'b0000};
        end
      end
      MOP_SW: begin
        if (lane_s != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          wmask    = MASK_W;
          wdata_sh = wdata;
        end
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-memory initiator: issues one dmem request per EX/MEM op,
// stalls the pipeline until the response, and presents the raw response plus
// the request fields of the completed op to MEM/WB.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        ext_stall,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  rsp_rmask,
  output logic [3:0]  rsp_wmask,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_wdata,
  output logic        misaligned,
  output logic        timeout_err
);

  localparam logic        TMO_EN    = (TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  mem_ctrl_state_t state_r;
  mem_ctrl_state_t next_state_s;

  logic [3:0]  al_rmask_s;
  logic [3:0]  al_wmask_s;
  logic [31:0] al_wdata_s;
  logic        al_mis_s;
  logic        al_op_valid_s;

  logic [31:0] addr_r;
  logic [3:0]  rmask_r;
  logic [3:0]  wmask_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;

  logic [15:0] wd_cnt_r;
  logic [15:0] wait_idx_s;
  logic        tmo_hit_s;
  logic        tmo_r;

  logic        req_live_s;
  logic        issue_s;
  logic        resp_s;
  logic        mis_s;

  mem_req_ctrl_align u_align (
    .op         (req_op),
    .addr       (req_addr),
    .wdata      (req_wdata),
    .rmask      (al_rmask_s),
    .wmask      (al_wmask_s),
    .wdata_sh   (al_wdata_s),
    .misaligned (al_mis_s),
    .op_valid   (al_op_valid_s)
  );

  // Only IDLE looks at a new op; WAIT/DONE are still serving the held one.
  assign req_live_s = (state_r == S_IDLE) && req_valid && al_op_valid_s;
  assign issue_s    = req_live_s && !al_mis_s;
  assign mis_s      = req_live_s && al_mis_s;
  assign resp_s     = (state_r == S_WAIT) && dmem_resp;

  // The watchdog index is the 1-based number of the current WAIT cycle.
  assign wait_idx_s = wd_cnt_r + 16'd1;
  assign tmo_hit_s  = TMO_EN && (state_r == S_WAIT) && (wait_idx_s == TIMEOUT_W);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: one request per op, DONE absorbs a lingering ext_stall.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (issue_s) begin
          next_state_s = S_WAIT;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_resp) begin
          next_state_s = ext_stall ? S_DONE : S_IDLE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_DONE: begin
        if (!ext_stall) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Request and response latches feeding the held dmem bus and rsp_* fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= 32'h0000_0000;
      rmask_r <= 4'b0000;
      wmask_r <= 4'b0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      if (issue_s) begin
        addr_r  <= word_addr(req_addr);
        rmask_r <= al_rmask_s;
        wmask_r <= al_wmask_s;
        wdata_r <= al_wdata_s;
      end
      if (resp_s) begin
        rdata_r <= dmem_rdata;
      end
    end
  end

  // Watchdog counter and sticky timeout flag; the FSM keeps waiting regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= 16'd0;
      tmo_r    <= 1'b0;
    end else begin
      if (issue_s) begin
        wd_cnt_r <= 16'd0;
      end else if ((state_r == S_WAIT) && (wd_cnt_r != 16'hFFFE)) begin
        wd_cnt_r <= wait_idx_s;
      end
      tmo_r <= tmo_r | tmo_hit_s;
    end
  end

  // Output logic: issue-cycle masks, held bus in WAIT, response presentation.
  always_comb begin
    dmem_addr   = addr_r;
    dmem_rmask  = 4'b0000;
    dmem_wmask  = 4'b0000;
    dmem_wdata  = wdata_r;
    stall       = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = rdata_r;
    rsp_rmask   = rmask_r;
    rsp_wmask   = wmask_r;
    rsp_addr    = addr_r;
    rsp_wdata   = wdata_r;
    misaligned  = mis_s;
    timeout_err = tmo_r | tmo_hit_s;
    case (state_r)
      S_IDLE: begin
        if (issue_s) begin
          dmem_addr  = word_addr(req_addr);
          dmem_rmask = al_rmask_s;
          dmem_wmask = al_wmask_s;
          dmem_wdata = al_wdata_s;
          stall      = 1'b1;
        end else begin
          stall      = 1'b0;
        end
        rsp_valid = mis_s;
      end
      S_WAIT: begin
        stall = !dmem_resp;
        if (dmem_resp) begin
          rsp_valid = 1'b1;
          rsp_rdata = dmem_rdata;
        end else begin
          rsp_valid = 1'b0;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with hand-computed expectations.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ext_stall;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_rmask;
  logic [3:0]  rsp_wmask;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_wdata;
  logic        misaligned;
  logic        timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  mem_req_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .ext_stall(ext_stall),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_rmask(rsp_rmask), .rsp_wmask(rsp_wmask), .rsp_addr(rsp_addr),
    .rsp_wdata(rsp_wdata), .misaligned(misaligned), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point, half a cycle away from the active edge.
  task automatic settle();
    @(negedge clk);
  endtask

  // Aligned op: issue cycle, one WAIT cycle carrying the response, then release.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] erm, input logic [3:0] ewm,
                       input logic [31:0] ewd, input logic [31:0] rd);
    logic [31:0] ea;
    ea = a & 32'hFFFF_FFFC;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    settle();
    chk({tag, ".rmask"}, dmem_rmask, erm);
    chk({tag, ".wmask"}, dmem_wmask, ewm);
    chk({tag, ".wdata"}, dmem_wdata, ewd);
    chk({tag, ".addr"}, dmem_addr, ea);
    chk({tag, ".stall"}, stall, 1'b1);
    cyc();
    chk({tag, ".no_resp_in_issue"}, {dmem_rmask, dmem_wmask}, 8'h00);
    dmem_resp = 1'b1; dmem_rdata = rd;
    settle();
    chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, rd);
    chk({tag, ".rsp_masks"}, {rsp_rmask, rsp_wmask}, {erm, ewm});
    chk({tag, ".rsp_wdata"}, rsp_wdata, ewd);
    chk({tag, ".rsp_addr"}, rsp_addr, ea);
    chk({tag, ".stall_resp"}, stall, 1'b0);
    cyc();
    dmem_resp = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = OP_NONE; req_addr = 32'h0;
    req_wdata = 32'h0; ext_stall = 1'b0; dmem_rdata = 32'h0; dmem_resp = 1'b0;

    // Reset state
    settle();
    chk("rst.masks", {dmem_rmask, dmem_wmask}, 8'h00);
    chk("rst.stall", stall, 1'b0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.flags", {misaligned, timeout_err}, 2'b00);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // LW 0x1000, response on the third cycle after issue
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_1000; req_wdata = 32'h0;
    settle();
    chk("lw.rmask", dmem_rmask, 4'hF);
    chk("lw.stall0", stall, 1'b1);
    chk("lw.addr", dmem_addr, 32'h0000_1000);
    cyc();
    for (int i = 1; i <= 2; i++) begin
      settle();
      chk("lw.rmask_wait", dmem_rmask, 4'h0);
      chk("lw.stall_wait", stall, 1'b1);
      chk("lw.rsp_valid_wait", rsp_valid, 1'b0);
      cyc();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("lw.stall_resp", stall, 1'b0);
    chk("lw.rsp_valid", rsp_valid, 1'b1);
    chk("lw.rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw.tmo", timeout_err, 1'b0);
    cyc();
    dmem_resp = 1'b0; dmem_rdata = 32'h0; req_valid = 1'b0;
    settle();
    chk("lw.idle_rsp_valid", rsp_valid, 1'b0);
    chk("lw.idle_rdata_held", rsp_rdata, 32'hDEAD_BEEF);
    cyc();

    // SB 0x1003 plus a table of lane/mask vectors
    do_op("sb1003", OP_SB, 32'h0000_1003, 32'h0000_00A5, 4'b0000, 4'b1000, 32'hA500_0000, 32'h0);
    do_op("lb101",  OP_LB,  32'h0000_0101, 32'h0, 4'b0010, 4'b0000, 32'h0, 32'h0000_0011);
    do_op("lbu102", OP_LBU, 32'h0000_0102, 32'h0, 4'b0100, 4'b0000, 32'h0, 32'h0000_2200);
    do_op("lhu102", OP_LHU, 32'h0000_0102, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'h3333_0000);
    do_op("lh100",  OP_LH,  32'h0000_0100, 32'h0, 4'b0011, 4'b0000, 32'h0, 32'h0000_4444);
    do_op("sh202",  OP_SH,  32'h0000_0202, 32'h0000_BEEF, 4'b0000, 4'b1100, 32'hBEEF_0000, 32'h0);
    do_op("sw300",  OP_SW,  32'h0000_0300, 32'h1122_3344, 4'b0000, 4'b1111, 32'h1122_3344, 32'h0);
    do_op("sb301",  OP_SB,  32'h0000_0301, 32'hFFFF_FF5A, 4'b0000, 4'b0010, 32'hFFFF_5A00, 32'h0);
    do_op("lw400",  OP_LW,  32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 4'b0000, 32'h0, 32'h5555_AAAA);

    // Misaligned SH and LW: no request, single-cycle rsp_valid
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h0000_1001; req_wdata = 32'h1234;
    settle();
    chk("sh_mis.flag", misaligned, 1'b1);
    chk("sh_mis.masks", {dmem_rmask, dmem_wmask}, 8'h00);
    chk("sh_mis.stall", stall, 1'b0);
    chk("sh_mis.rsp_valid", rsp_valid, 1'b1);
    cyc();
    req_op = OP_LW; req_addr = 32'h0000_0402;
    settle();
    chk("lw_mis.flag", misaligned, 1'b1);
    chk("lw_mis.rmask", dmem_rmask, 4'h0);
    cyc();
    req_valid = 1'b0;
    settle();
    chk("mis.clear", {misaligned, rsp_valid}, 2'b00);
    cyc();

    // LW completed while ext_stall holds the pipeline
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_3004; ext_stall = 1'b1;
    settle();
    chk("xs.rmask", dmem_rmask, 4'hF);
    cyc();
    dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    settle();
    chk("xs.rsp_valid_resp", rsp_valid, 1'b1);
    chk("xs.rdata_resp", rsp_rdata, 32'h1234_5678);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      dmem_resp = (i == 2);
      dmem_rdata = 32'h0BAD_F00D;
      ext_stall = (i != 4);
      settle();
      chk("xs.done_rsp_valid", rsp_valid, 1'b1);
      chk("xs.done_rmask", dmem_rmask, 4'h0);
      chk("xs.done_stall", stall, 1'b0);
      chk("xs.done_rdata", rsp_rdata, 32'h1234_5678);
      cyc();
    end
    dmem_resp = 1'b0; req_valid = 1'b0;
    settle();
    chk("xs.idle_rsp_valid", rsp_valid, 1'b0);
    chk("xs.idle_rdata", rsp_rdata, 32'h1234_5678);
    cyc();

    // Reset mid-WAIT, then a stray response
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_4000;
    settle();
    chk("rw.rmask", dmem_rmask, 4'hF);
    cyc();
    settle();
    chk("rw.stall_wait", stall, 1'b1);
    cyc();
    rst = 1'b1; req_valid = 1'b0;
    settle();
    chk("rw.stall", stall, 1'b0);
    chk("rw.rsp_valid", rsp_valid, 1'b0);
    chk("rw.rsp_rdata", rsp_rdata, 32'h0);
    chk("rw.addr", {dmem_addr, rsp_addr}, 64'h0);
    cyc();
    rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("rw.stray_rsp_valid", rsp_valid, 1'b0);
    chk("rw.stray_stall", stall, 1'b0);
    cyc();
    dmem_resp = 1'b0;
    settle();
    chk("rw.stray_rdata", rsp_rdata, 32'h0);
    cyc();
    do_op("lh2002", OP_LH, 32'h0000_2002, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'h7777_0000);

    // Watchdog: no response for 6 WAIT cycles
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_5000;
    settle();
    chk("wd.tmo_issue", timeout_err, 1'b0);
    cyc();
    for (int i = 1; i <= 6; i++) begin
      settle();
      chk("wd.stall", stall, 1'b1);
      chk("wd.tmo", timeout_err, (i >= 4));
      cyc();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'h600D_600D;
    settle();
    chk("wd.rsp_valid", rsp_valid, 1'b1);
    chk("wd.tmo_resp", timeout_err, 1'b1);
    cyc();
    dmem_resp = 1'b0; req_valid = 1'b0;
    settle();
    chk("wd.tmo_sticky", timeout_err, 1'b1);
    chk("wd.rdata", rsp_rdata, 32'h600D_600D);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
